// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap_pkg : opcodes, control words and T-state type for SAP sequencer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package sap_pkg;

  typedef enum logic [3:0] {
    LDA = 4'b0000,
    ADD = 4'b0001,
    SUB = 4'b0010,
    OUT = 4'b1110,
    HLT = 4'b1111
  } opcode_e;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_NLM = 9;
  localparam int CW_NCE = 8;
  localparam int CW_NLI = 7;
  localparam int CW_NEI = 6;
  localparam int CW_NLA = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_NLB = 1;
  localparam int CW_NLO = 0;

  localparam logic [11:0] IDLE       = 12'h3E3;
  localparam logic [11:0] FETCH_T1   = 12'h5E3;
  localparam logic [11:0] FETCH_T2   = 12'hBE3;
  localparam logic [11:0] FETCH_T3   = 12'h263;
  localparam logic [11:0] EXEC_MAR   = 12'h1A3;
  localparam logic [11:0] LDA_T5     = 12'h2C3;
  localparam logic [11:0] ADDSUB_T5  = 12'h2E1;
  localparam logic [11:0] ADD_T6     = 12'h3C7;
  localparam logic [11:0] SUB_T6     = 12'h3CF;
  localparam logic [11:0] OUT_T4     = 12'h3F2;

endpackage
`default_nettype wire

// File: rtl/sap_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap_sequencer_if : run/opcode in, control word and status out       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface sap_sequencer_if;
  logic        run;
  logic [3:0]  instruction;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halted;
  logic        instr_done;

  modport master (
    output run, instruction,
    input  control_word, t_state, halted, instr_done
  );

  modport slave (
    input  run, instruction,
    output control_word, t_state, halted, instr_done
  );
endinterface
`default_nettype wire

// File: rtl/sap_sequencer_ring_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ring_counter : one-hot T1..T6 ring, advances when enable is high    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ring_counter
  import sap_pkg::*;
(
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic enable,
  output t_state_e  state
);

  t_state_e r_state;
  t_state_e w_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= T1;
    else       r_state <= w_next;
  end

  // Any non-one-hot value falls back to T1.
  always_comb begin
    w_next = r_state;
    if (enable) begin
      case (r_state)
        T1:      w_next = T2;
        T2:      w_next = T3;
        T3:      w_next = T4;
        T4:      w_next = T5;
        T5:      w_next = T6;
        T6:      w_next = T1;
        default: w_next = T1;
      endcase
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/sap_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sap_sequencer : SAP-1 T-state sequencer and microcode decoder       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sap_sequencer
  import sap_pkg::*;
(
  input  wire logic      clock,
  input  wire logic      reset,
  sap_sequencer_if.slave bus
);

  t_state_e    w_t_state;
  logic        r_halted;
  logic        w_hlt_edge;
  logic        w_advance;
  logic [11:0] w_cw;

  // HLT freezes the ring at T4 on the same edge that sets halted.
  assign w_hlt_edge = bus.run && !r_halted && (w_t_state == T4) &&
                      (bus.instruction == HLT);
  assign w_advance  = bus.run && !r_halted && !w_hlt_edge;

  ring_counter u_ring (
    .clock  (clock),
    .reset  (reset),
    .enable (w_advance),
    .state  (w_t_state)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_halted <= 1'b0;
    else if (w_hlt_edge) r_halted <= 1'b1;
  end

  always_comb begin
    w_cw = IDLE;
    if (reset) begin
      w_cw = FETCH_T1;
    end else if (bus.run && !r_halted) begin
      case (w_t_state)
        T1: w_cw = FETCH_T1;
        T2: w_cw = FETCH_T2;
        T3: w_cw = FETCH_T3;
        T4: begin
          case (bus.instruction)
            LDA, ADD, SUB: w_cw = EXEC_MAR;
            OUT:           w_cw = OUT_T4;
            default:       w_cw = IDLE;
          endcase
        end
        T5: begin
          case (bus.instruction)
            LDA:      w_cw = LDA_T5;
            ADD, SUB: w_cw = ADDSUB_T5;
            default:  w_cw = IDLE;
          endcase
        end
        T6: begin
          case (bus.instruction)
            ADD:     w_cw = ADD_T6;
            SUB:     w_cw = SUB_T6;
            default: w_cw = IDLE;
          endcase
        end
        default: w_cw = IDLE;
      endcase
    end
  end

  assign bus.control_word = w_cw;
  assign bus.t_state      = w_t_state;
  assign bus.halted       = r_halted;
  assign bus.instr_done   = (w_t_state == T6) && bus.run && !r_halted && !reset;

endmodule
`default_nettype wire

// File: tb/tb_sap_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sap_sequencer : directed + random checks against a step model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_sap_sequencer;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   m_step;
  bit   m_halt;

  sap_sequencer_if bus ();

  sap_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, m_step);
    end
  endtask

  // Microstep table: step 0..5 = T1..T6.
  function automatic logic [11:0] exp_cw(input int step, input logic [3:0] op,
                                         input bit rst, input bit rn, input bit h);
    if (rst) return 12'h5E3;
    if (!rn || h) return 12'h3E3;
    if (step == 0) return 12'h5E3;
    if (step == 1) return 12'hBE3;
    if (step == 2) return 12'h263;
    case (op)
      4'b0000: return (step == 3) ? 12'h1A3 : (step == 4) ? 12'h2C3 : 12'h3E3;
      4'b0001: return (step == 3) ? 12'h1A3 : (step == 4) ? 12'h2E1 : 12'h3C7;
      4'b0010: return (step == 3) ? 12'h1A3 : (step == 4) ? 12'h2E1 : 12'h3CF;
      4'b1110: return (step == 3) ? 12'h3F2 : 12'h3E3;
      default: return 12'h3E3;
    endcase
  endfunction

  function automatic int bus_drivers(input logic [11:0] cw);
    return int'(cw[10]) + int'(!cw[8]) + int'(!cw[6]) + int'(cw[4]) + int'(cw[2]);
  endfunction

  task automatic model_reset();
    m_step = 0;
    m_halt = 1'b0;
  endtask

  task automatic model_update();
    if (!reset && bus.run && !m_halt) begin
      if (m_step == 3 && bus.instruction == 4'b1111) m_halt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic check_outputs();
    logic [11:0] cw;
    cw = exp_cw(m_step, bus.instruction, reset, bus.run, m_halt);
    check("control_word", 32'(bus.control_word), 32'(cw));
    check("t_state", 32'(bus.t_state), 32'(6'b1 << m_step));
    check("halted", 32'(bus.halted), 32'(m_halt));
    check("instr_done", 32'(bus.instr_done),
          32'(m_step == 5 && bus.run && !m_halt && !reset));
    check("one_driver", 32'(bus_drivers(bus.control_word) <= 1), 32'd1);
  endtask

  task automatic do_cycle();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  // Asynchronous pulse placed mid-cycle, checked before any clock edge.
  task automatic reset_pulse();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.run = 1'b0;
    bus.instruction = 4'b0000;
    model_reset();
    @(negedge clock);
    check_outputs();
    bus.run = 1'b1;
    #1;
    check_outputs();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // LDA, then two SUBs.
    bus.instruction = 4'b0000;
    repeat (6) do_cycle();
    bus.instruction = 4'b0010;
    repeat (12) do_cycle();

    // ADD frozen in T5 for five cycles.
    bus.instruction = 4'b0001;
    repeat (4) do_cycle();
    bus.run = 1'b0;
    repeat (5) do_cycle();
    bus.run = 1'b1;
    repeat (2) do_cycle();

    // ADD interrupted by reset during T6.
    repeat (5) do_cycle();
    reset_pulse();

    // NOP opcode then OUT.
    bus.instruction = 4'b0101;
    repeat (6) do_cycle();
    bus.instruction = 4'b1110;
    repeat (6) do_cycle();

    // HLT then 20 idle cycles, recovered by reset.
    bus.instruction = 4'b1111;
    repeat (24) do_cycle();
    reset_pulse();
    repeat (2) do_cycle();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) bus.instruction = 4'($urandom_range(0, 15));
      bus.run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0 || (m_halt && $urandom_range(0, 7) == 0))
        reset_pulse();
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_sequencer.md
SAP_SEQUENCER -- requirements
Module: sap_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state changes on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all sequencer state.
REQ-003 SHALL have port: run  input  1  advance enable; 0 freezes the T-state and forces the idle control word.
REQ-004 SHALL have port: instruction  input  4  opcode nibble from the instruction register, sampled during T4-T6 only.
REQ-005 SHALL have port: control_word  output  12  bits 11..0 = {Cp, Ep, nLm, nCe, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}; n = active-low.
REQ-006 SHALL have port: t_state  output  6  one-hot ring-counter state, bit0 = T1 ... bit5 = T6.
REQ-007 SHALL have port: halted  output  1  high after HLT executes, sticky until reset.
REQ-008 SHALL have port: instr_done  output  1  high during T6 while run=1 and halted=0.

Function
REQ-009 SHALL advance t_state T1->T2->...->T6->T1, one step per posedge with run=1 and halted=0.
REQ-010 SHALL hold t_state unchanged on any posedge with run=0 or halted=1.
REQ-011 SHALL drive control_word combinationally from t_state and instruction, with zero-cycle latency.
REQ-012 SHALL drive IDLE = 12'h3E3 whenever run=0, halted=1, or no microstep below applies.
REQ-013 SHALL drive the fetch words, independent of opcode: T1 = 12'h5E3 (Ep, nLm); T2 = 12'hBE3 (Cp); T3 = 12'h263 (nCe, nLi).
REQ-014 SHALL, for LDA (4'b0000), drive T4 = 12'h1A3 (Ei, nLm), T5 = 12'h2C3 (nCe, nLa), T6 = IDLE.
REQ-015 SHALL, for ADD (4'b0001), drive T4 = 12'h1A3, T5 = 12'h2E1 (nCe, nLb), T6 = 12'h3C7 (nLa, Eu).
REQ-016 SHALL, for SUB (4'b0010), drive the ADD words except T6 = 12'h3CF (nLa, Eu, Su).
REQ-017 SHALL, for OUT (4'b1110), drive T4 = 12'h3F2 (Ea, nLo), T5 = IDLE, T6 = IDLE.
REQ-018 SHALL, for HLT (4'b1111), drive IDLE in T4 and set halted on the posedge ending T4 (run=1); t_state then stays at T4.
REQ-019 SHALL treat every other opcode as a NOP: IDLE in T4-T6 and normal advance.
REQ-020 SHALL never assert more than one bus driver (Ep, nCe low, nEi low, Ea, Eu) in the same cycle.
REQ-021 SHALL suppress instr_done while run=0 or halted=1; when HLT is the last instruction, instr_done is never asserted for it.
REQ-022 SHALL ignore changes on instruction during T1-T3; they have no effect on control_word.
REQ-023 SHALL resume exactly at the frozen T-state and microstep when run returns to 1.

Reset
REQ-024 SHALL, on reset assertion at any time (including mid-instruction or while halted), immediately set t_state = 6'b000001 and halted = 0.
REQ-025 SHALL output control_word = 12'h5E3 and instr_done = 0 while reset is high.
REQ-026 SHALL start a fresh fetch at T1 on the first posedge after reset deasserts with run=1.

Structure
REQ-027 SHALL take the following from shared package sap_pkg: opcode enum (LDA, ADD, SUB, OUT, HLT), 12-bit control word constants (IDLE, FETCH_T1..T3, etc.), control-bit index localparams, and the T-state one-hot type.
REQ-028 SHALL implement the T-state sequencing as sub-module ring_counter (6-bit one-hot, async reset, enable input).
REQ-029 SHALL implement the decode as a single combinational microcode block in sap_sequencer.

Verification
REQ-030 SHALL cover: reset, run=1, instruction=LDA -> control_word 5E3, BE3, 263, 1A3, 2C3, 3E3 over six cycles; instr_done high in cycle 6 only.
REQ-031 SHALL cover: instruction=SUB for two instruction cycles -> T6 = 3CF both times; t_state wraps 100000->000001.
REQ-032 SHALL cover: instruction=HLT -> halted=1 after the T4 edge; t_state = 001000 and control_word = 3E3 for 20 further cycles.
REQ-033 SHALL cover: run=0 during T5 of ADD for 5 cycles -> t_state holds 010000, control_word = 3E3; on run=1, control_word = 2E1 and the sequence continues.
REQ-034 SHALL cover: reset pulsed mid-T6 of ADD -> t_state = 000001 and control_word = 5E3 asynchronously, before the next posedge.
REQ-035 SHALL cover: opcode 4'b0101 and OUT -> NOP yields IDLE in T4-T6; OUT yields 3F2 in T4; one-driver assertion holds every cycle.
